// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Registered N-port arbiter placing one per-core memory bus at a time onto
//   the shared memory bus. Round-robin (MODE 0) or fixed lowest-index
//   priority (MODE 1). A grant is held until mem_done, until the owner drops
//   its request (abort), or until the watchdog expires (TIMEOUT cycles).
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   port_addr/wdata/wmask           per-port bus fields, port i in slice i
//   port_wstrb/port_rstrb           per-port request levels
//   port_rdata                      mem_rdata passed to every port
//   port_done / port_err            per-port completion / timeout pulse
//   mem_addr/wdata/wmask/wstrb/rstrb shared bus, driven from granted port
//   mem_rdata, mem_done             shared bus response
//   granted                         registered one-hot grant (0 when idle)
module mem_bus_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MODE       = 0,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*32-1:0]         port_wdata,
  input  logic [NUM_PORTS*4-1:0]          port_wmask,
  input  logic [NUM_PORTS-1:0]            port_wstrb,
  input  logic [NUM_PORTS-1:0]            port_rstrb,
  output logic [31:0]                     port_rdata,
  output logic [NUM_PORTS-1:0]            port_done,
  output logic [NUM_PORTS-1:0]            port_err,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [31:0]                     mem_wdata,
  output logic [3:0]                      mem_wmask,
  output logic                            mem_wstrb,
  output logic                            mem_rstrb,
  input  logic [31:0]                     mem_rdata,
  input  logic                            mem_done,
  output logic [NUM_PORTS-1:0]            granted
);

  localparam int unsigned   PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] WD_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] granted_q, granted_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        wdog_q, wdog_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] win_oh;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        scan;
  logic                 found;
  logic                 owner_req;
  logic                 timeout;

  assign req        = port_rstrb | port_wstrb;
  assign owner_req  = |(req & granted_q);
  assign granted    = granted_q;
  assign port_rdata = mem_rdata;
  assign port_done  = mem_done ? granted_q : '0;
  assign port_err   = timeout ? granted_q : '0;

  // Winner selection. Round-robin walks upward from ptr+1 with wrap; the
  // scan index is stepped modulo NUM_PORTS so it never leaves the port range.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    found   = 1'b0;
    scan    = ptr_q;
    if (MODE == 0) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        scan = (scan == PTR_LAST) ? '0 : scan + PW'(1);
        if (!found && req[scan]) begin
          found   = 1'b1;
          win_idx = scan;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          found   = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
    win_oh[win_idx] = 1'b1;
  end

  // Bus mux: all-zero when nothing is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_wstrb = 1'b0;
    mem_rstrb = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (granted_q[i]) begin
        mem_addr  = port_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        mem_wdata = port_wdata[32*i +: 32];
        mem_wmask = port_wmask[4*i +: 4];
        mem_wstrb = port_wstrb[i];
        mem_rstrb = port_rstrb[i];
      end
    end
  end

  // Release priority in BUSY: mem_done, then abort, then watchdog expiry.
  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = BUSY;
          granted_d = win_oh;
          ptr_d     = win_idx;
          wdog_d    = '0;
        end
      end
      BUSY: begin
        if (mem_done || !owner_req) begin
          state_d   = IDLE;
          granted_d = '0;
        end else if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
          timeout   = 1'b1;
          state_d   = IDLE;
          granted_d = '0;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        granted_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      granted_q <= '0;
      ptr_q     <= PTR_LAST;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share all
// inputs; directed scenarios check fixed expectations and a random phase
// compares every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int NP = 4;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic [127:0]  port_addr;
  logic [127:0]  port_wdata;
  logic [15:0]   port_wmask;
  logic [3:0]    port_wstrb;
  logic [3:0]    port_rstrb;
  logic [31:0]   mem_rdata;
  logic          mem_done;

  logic [31:0] rdata_rr, rdata_fp, maddr_rr, maddr_fp, mwdata_rr, mwdata_fp;
  logic [3:0]  done_rr, done_fp, err_rr, err_fp, granted_rr, granted_fp;
  logic [3:0]  mwmask_rr, mwmask_fp;
  logic        mwstrb_rr, mwstrb_fp, mrstrb_rr, mrstrb_fp;

  int n_cmp;
  int n_bad;

  // Reference model state per instance (0 = round-robin, 1 = fixed).
  int m_owner [2];   // granted port, -1 when idle
  int m_last  [2];   // last port granted
  int m_age   [2];   // busy cycles already elapsed in current grant

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .MODE(0), .TIMEOUT(TO)) u_rr (
    .clk(clk), .reset(reset), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_wmask(port_wmask), .port_wstrb(port_wstrb), .port_rstrb(port_rstrb),
    .port_rdata(rdata_rr), .port_done(done_rr), .port_err(err_rr),
    .mem_addr(maddr_rr), .mem_wdata(mwdata_rr), .mem_wmask(mwmask_rr),
    .mem_wstrb(mwstrb_rr), .mem_rstrb(mrstrb_rr), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .granted(granted_rr));

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .MODE(1), .TIMEOUT(TO)) u_fp (
    .clk(clk), .reset(reset), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_wmask(port_wmask), .port_wstrb(port_wstrb), .port_rstrb(port_rstrb),
    .port_rdata(rdata_fp), .port_done(done_fp), .port_err(err_fp),
    .mem_addr(maddr_fp), .mem_wdata(mwdata_fp), .mem_wmask(mwmask_fp),
    .mem_wstrb(mwstrb_fp), .mem_rstrb(mrstrb_fp), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .granted(granted_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: a grant lasts until done, request drop, or
  // TO busy cycles; round-robin picks the next requester after the last one.
  always @(posedge clk or posedge reset) begin
    logic [3:0] r;
    int w;
    int c;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] <= -1;
        m_last[k]  <= NP - 1;
        m_age[k]   <= 0;
      end
    end else begin
      r = port_rstrb | port_wstrb;
      for (int k = 0; k < 2; k++) begin
        if (m_owner[k] < 0) begin
          if (r != 4'b0) begin
            w = -1;
            if (k == 0) begin
              for (int off = 1; off <= NP; off++) begin
                c = (m_last[k] + off) % NP;
                if (w < 0 && r[c]) w = c;
              end
            end else begin
              for (int i = NP - 1; i >= 0; i--) if (r[i]) w = i;
            end
            m_owner[k] <= w;
            m_last[k]  <= w;
            m_age[k]   <= 0;
          end
        end else if (mem_done || !r[m_owner[k]] || m_age[k] == TO - 1) begin
          m_owner[k] <= -1;
        end else begin
          m_age[k] <= m_age[k] + 1;
        end
      end
    end
  end

  function automatic logic [113:0] exp_vec(int k);
    logic [3:0] g, d, e, wm;
    logic [31:0] a, wd;
    logic ws, rs;
    int o;
    o = m_owner[k];
    g = '0; d = '0; e = '0; wm = '0; a = '0; wd = '0; ws = 1'b0; rs = 1'b0;
    if (o >= 0) begin
      g  = 4'(1 << o);
      a  = port_addr[o*32 +: 32];
      wd = port_wdata[o*32 +: 32];
      wm = port_wmask[o*4 +: 4];
      ws = port_wstrb[o];
      rs = port_rstrb[o];
      if (mem_done) d = g;
      else if ((ws || rs) && m_age[k] == TO - 1) e = g;
    end
    return {g, d, e, a, wd, wm, ws, rs, mem_rdata};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    port_addr  = '0;
    port_wdata = '0;
    port_wmask = '0;
    port_wstrb = '0;
    port_rstrb = '0;
    mem_rdata  = '0;
    mem_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    port_rstrb = 4'b0001;
    port_wstrb = 4'b0001;
    port_addr[31:0] = 32'hDEAD_BEEF;
    mem_done = 1'b1;
    #3;
    n_cmp++; if (granted_rr !== 4'b0 || granted_fp !== 4'b0) begin n_bad++;
      $display("FAIL reset_granted: got rr=%b fp=%b want 0000", granted_rr, granted_fp); end
    n_cmp++; if ({maddr_rr, mwstrb_rr, mrstrb_rr} !== 34'b0) begin n_bad++;
      $display("FAIL reset_bus: got addr=%h w=%b r=%b want 0", maddr_rr, mwstrb_rr, mrstrb_rr); end
    n_cmp++; if ({done_rr, err_rr, done_fp, err_fp} !== 16'b0) begin n_bad++;
      $display("FAIL reset_done_err: got %h want 0000", {done_rr, err_rr, done_fp, err_fp}); end
    do_reset();
    mem_done = 1'b1;
    @(negedge clk);
    n_cmp++; if (done_rr !== 4'b0 || granted_rr !== 4'b0) begin n_bad++;
      $display("FAIL idle_done_ignored: got done=%b granted=%b want 0000/0000", done_rr, granted_rr); end
    cyc();
    mem_done = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    port_rstrb[1] = 1'b1;
    port_addr[63:32] = 32'h0000_0100;
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0000) begin n_bad++;
      $display("FAIL single_latency: got %b want 0000", granted_rr); end
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0010 || granted_fp !== 4'b0010) begin n_bad++;
      $display("FAIL single_grant: got rr=%b fp=%b want 0010", granted_rr, granted_fp); end
    n_cmp++; if (maddr_rr !== 32'h100 || mrstrb_rr !== 1'b1 || mwstrb_rr !== 1'b0) begin n_bad++;
      $display("FAIL single_bus: got addr=%h r=%b w=%b want 100/1/0", maddr_rr, mrstrb_rr, mwstrb_rr); end
    repeat (3) cyc();
    mem_done = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (done_rr !== 4'b0010 || done_fp !== 4'b0010 || err_rr !== 4'b0) begin n_bad++;
      $display("FAIL single_done: got done=%b err=%b want 0010/0000", done_rr, err_rr); end
    n_cmp++; if (rdata_rr !== 32'h1234_5678) begin n_bad++;
      $display("FAIL single_rdata: got %h want 12345678", rdata_rr); end
    cyc();
    mem_done = 1'b0;
    port_rstrb = '0;
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0 || done_rr !== 4'b0) begin n_bad++;
      $display("FAIL single_release: got granted=%b done=%b want 0000/0000", granted_rr, done_rr); end
  endtask

  task automatic test_round_robin();
    int dcnt [4];
    logic [3:0] exp;
    do_reset();
    for (int p = 0; p < 4; p++) dcnt[p] = 0;
    port_rstrb = 4'hF;
    port_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    for (int t = 0; t < 8; t++) begin
      cyc();
      mem_done = 1'b1;
      @(negedge clk);
      exp = 4'b0001 << (t % 4);
      n_cmp++; if (granted_rr !== exp || done_rr !== exp) begin n_bad++;
        $display("FAIL rr_order t=%0d: got grant=%b done=%b want %b", t, granted_rr, done_rr, exp); end
      n_cmp++; if (granted_fp !== 4'b0001) begin n_bad++;
        $display("FAIL fp_order t=%0d: got %b want 0001", t, granted_fp); end
      for (int p = 0; p < 4; p++) if (done_rr[p]) dcnt[p]++;
      cyc();
      mem_done = 1'b0;
      @(negedge clk);
      n_cmp++; if (granted_rr !== 4'b0) begin n_bad++;
        $display("FAIL rr_gap t=%0d: got %b want 0000", t, granted_rr); end
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if (dcnt[p] != 2) begin n_bad++;
        $display("FAIL rr_fair port%0d: got %0d dones want 2", p, dcnt[p]); end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    port_rstrb = 4'b0101;
    for (int t = 0; t < 3; t++) begin
      cyc();
      mem_done = 1'b1;
      @(negedge clk);
      n_cmp++; if (granted_fp !== 4'b0001) begin n_bad++;
        $display("FAIL fp_prio t=%0d: got %b want 0001", t, granted_fp); end
      cyc();
      mem_done = 1'b0;
    end
    port_rstrb[0] = 1'b0;
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_fp !== 4'b0100) begin n_bad++;
      $display("FAIL fp_after_drop: got %b want 0100", granted_fp); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    do_reset();
    port_wstrb[0] = 1'b1;
    port_wdata[31:0] = 32'hCAFE_0001;
    cyc();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      exp = (c == TO) ? 4'b0001 : 4'b0000;
      n_cmp++; if (err_rr !== exp || err_fp !== exp || done_rr !== 4'b0) begin n_bad++;
        $display("FAIL timeout c=%0d: got err=%b/%b done=%b want %b/0000", c, err_rr, err_fp, done_rr, exp); end
      n_cmp++; if (granted_rr !== 4'b0001 || mwstrb_rr !== 1'b1) begin n_bad++;
        $display("FAIL timeout_hold c=%0d: got grant=%b w=%b want 0001/1", c, granted_rr, mwstrb_rr); end
      cyc();
    end
    port_wstrb = '0;
    port_rstrb = 4'b0010;
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0 || err_rr !== 4'b0) begin n_bad++;
      $display("FAIL timeout_release: got grant=%b err=%b want 0000/0000", granted_rr, err_rr); end
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0010) begin n_bad++;
      $display("FAIL timeout_next: got %b want 0010", granted_rr); end
  endtask

  task automatic test_abort_race();
    do_reset();
    port_rstrb[3] = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b1000) begin n_bad++;
      $display("FAIL abort_grant: got %b want 1000", granted_rr); end
    cyc();
    port_rstrb[3] = 1'b0;
    @(negedge clk);
    n_cmp++; if (done_rr !== 4'b0 || err_rr !== 4'b0 || mrstrb_rr !== 1'b0) begin n_bad++;
      $display("FAIL abort_quiet: got done=%b err=%b r=%b want 0000/0000/0", done_rr, err_rr, mrstrb_rr); end
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0) begin n_bad++;
      $display("FAIL abort_release: got %b want 0000", granted_rr); end
    do_reset();
    port_rstrb[0] = 1'b1;
    cyc();
    repeat (TO - 1) cyc();
    mem_done = 1'b1;
    @(negedge clk);
    n_cmp++; if (done_rr !== 4'b0001 || err_rr !== 4'b0 || done_fp !== 4'b0001 || err_fp !== 4'b0) begin n_bad++;
      $display("FAIL race: got done=%b err=%b want 0001/0000", done_rr, err_rr); end
    cyc();
    mem_done = 1'b0;
    port_rstrb = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    port_rstrb[2] = 1'b1;
    port_wstrb[2] = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0100 || mrstrb_rr !== 1'b1) begin n_bad++;
      $display("FAIL rmid_grant: got %b r=%b want 0100/1", granted_rr, mrstrb_rr); end
    cyc();
    #2 reset = 1'b1;
    mem_done = 1'b1;
    #1;
    n_cmp++; if (granted_rr !== 4'b0 || mrstrb_rr !== 1'b0 || mwstrb_rr !== 1'b0) begin n_bad++;
      $display("FAIL rmid_drop: got grant=%b r=%b w=%b want 0000/0/0", granted_rr, mrstrb_rr, mwstrb_rr); end
    n_cmp++; if (done_rr !== 4'b0 || err_rr !== 4'b0) begin n_bad++;
      $display("FAIL rmid_quiet: got done=%b err=%b want 0000/0000", done_rr, err_rr); end
    @(posedge clk);
    #1 reset = 1'b0;
    mem_done = 1'b0;
    port_wstrb = '0;
    port_rstrb = 4'b0101;
    cyc();
    @(negedge clk);
    n_cmp++; if (granted_rr !== 4'b0001) begin n_bad++;
      $display("FAIL rmid_first: got %b want 0001", granted_rr); end
  endtask

  task automatic test_random();
    logic [3:0] seen;
    logic [113:0] act, exp;
    do_reset();
    seen = '0;
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 4; p++) begin
        if (port_rstrb[p] || port_wstrb[p]) begin
          if (seen[p] || $urandom_range(0, 39) == 0) begin
            port_rstrb[p] = 1'b0;
            port_wstrb[p] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          port_addr[p*32 +: 32]  = $urandom;
          port_wdata[p*32 +: 32] = $urandom;
          port_wmask[p*4 +: 4]   = 4'($urandom);
          if ($urandom_range(0, 1) == 0) port_rstrb[p] = 1'b1;
          else port_wstrb[p] = 1'b1;
        end
      end
      mem_done  = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      @(negedge clk);
      act = {granted_rr, done_rr, err_rr, maddr_rr, mwdata_rr, mwmask_rr, mwstrb_rr, mrstrb_rr, rdata_rr};
      exp = exp_vec(0);
      n_cmp++; if (act !== exp) begin n_bad++;
        $display("FAIL rand_rr n=%0d: got %h want %h", n, act, exp); end
      act = {granted_fp, done_fp, err_fp, maddr_fp, mwdata_fp, mwmask_fp, mwstrb_fp, mrstrb_fp, rdata_fp};
      exp = exp_vec(1);
      n_cmp++; if (act !== exp) begin n_bad++;
        $display("FAIL rand_fp n=%0d: got %h want %h", n, act, exp); end
      n_cmp++; if (!$onehot0(granted_rr) || !$onehot0(done_rr | err_rr) || (done_rr & err_rr) != 4'b0) begin n_bad++;
        $display("FAIL rand_invariant n=%0d: got grant=%b done=%b err=%b want onehot0", n, granted_rr, done_rr, err_rr); end
      seen = done_rr | err_rr;
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    port_addr = '0; port_wdata = '0; port_wmask = '0;
    port_wstrb = '0; port_rstrb = '0;
    mem_rdata = '0; mem_done = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_abort_race();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Registered N-port arbiter that multiplexes the per-core merged instruction/data memory buses onto the single shared memory bus.
- Replaces the combinational grant-and-mux scheme in the multi-core SoC wrapper.
- Adds selectable round-robin or fixed-priority arbitration, grant locking until completion, request-abort release and a per-transaction watchdog timeout with error reporting.

Parameters:
- NUM_PORTS, 2, number of requesting ports (1..16).
- ADDR_WIDTH, 32, address width of ports and memory bus.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 256, cycles a granted transaction may wait for mem_done. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- port_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- port_wdata  in  NUM_PORTS*32  per-port write data
- port_wmask  in  NUM_PORTS*4  per-port byte write mask
- port_wstrb  in  NUM_PORTS  per-port write request (level)
- port_rstrb  in  NUM_PORTS  per-port read request (level)
- port_rdata  out  32  read data, shared by all ports
- port_done  out  NUM_PORTS  per-port completion pulse
- port_err  out  NUM_PORTS  per-port timeout pulse
- mem_addr  out  ADDR_WIDTH  shared bus address
- mem_wdata  out  32  shared bus write data
- mem_wmask  out  4  shared bus write mask
- mem_wstrb  out  1  shared bus write strobe
- mem_rstrb  out  1  shared bus read strobe
- mem_rdata  in  32  shared bus read data
- mem_done  in  1  shared bus completion
- granted  out  NUM_PORTS  one-hot current grant (registered)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-high, named reset.
- Reset values:
  - granted = 0, FSM = IDLE, watchdog counter = 0.
  - Round-robin pointer = NUM_PORTS-1, so port 0 wins first.
  - All mem_* outputs, port_done and port_err are 0.
- Request rules:
  - req[i] = port_rstrb[i] | port_wstrb[i].
  - A requester holds req and all its bus fields stable until it sees port_done[i] or port_err[i].
- FSM IDLE:
  - If any req is asserted, select a winner at the clock edge, set granted to one-hot(winner), go to BUSY and clear the watchdog.
  - Arbitration latency: 1 cycle from req to grant.
- Winner selection:
  - MODE 0: first asserted req searching upward from pointer+1, wrapping modulo NUM_PORTS. The pointer is updated to the winner when the grant is issued.
  - MODE 1: lowest asserted index.
- FSM BUSY, driving the bus:
  - mem_addr/wdata/wmask/wstrb/rstrb are combinationally muxed from the granted port.
  - When no port is granted, all mem_* outputs are forced to 0.
- FSM BUSY, completion:
  - port_done[g] = mem_done & granted[g], combinational, same cycle as mem_done.
  - port_rdata = mem_rdata at all times.
  - On the edge where mem_done=1: granted is cleared and the FSM returns to IDLE.
  - Minimum gap between consecutive grants is 1 idle cycle.
- FSM BUSY, abort:
  - If req[g] deasserts without mem_done, release at that edge back to IDLE.
  - No done or err is generated.
- FSM BUSY, watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle without mem_done.
  - When the count reaches TIMEOUT-1 and mem_done=0, assert port_err[g] for exactly 1 cycle (combinational on that cycle) and release to IDLE at the edge.
  - mem_done arriving in that same cycle wins: done is reported, err is not.
- Simultaneous events:
  - Requests arriving while BUSY wait.
  - Requests present on the release cycle are arbitrated from IDLE in the following cycle.
  - The round-robin pointer ensures every requester is served within NUM_PORTS grants.
- mem_done while IDLE is ignored: no done pulse, no state change.
- Reset mid-transaction: immediately drops the grant and all strobes, with no done or err emitted.
- Invariants:
  - At most one port_done bit or one port_err bit is set in any cycle.
  - granted is always 0 or one-hot.

Test Plan:
- Single request: port 1 rstrb, addr 0x0000_0100, mem_done 3 cycles after grant, mem_rdata 0x1234_5678 -> granted=0b10 one cycle after req; mem_addr=0x100, mem_rstrb=1; port_done[1] pulses with port_rdata 0x12345678; granted=0 the next cycle.
- Round-robin fairness: NUM_PORTS=4, MODE 0, all four requesting continuously, 1-cycle mem_done -> grant order 0,1,2,3,0,…; each port gets exactly 2 dones in 8 transactions.
- Fixed priority: MODE 1, ports 0 and 2 requesting continuously -> only port 0 is granted; port 2 is granted only after port 0 drops its request.
- Timeout: TIMEOUT=8, port 0 wstrb, mem_done never asserted -> port_err[0] pulses exactly 8 cycles after grant, no port_done; the next request is granted normally.
- Abort and done/timeout race: port 3 drops rstrb mid-BUSY -> release with no done/err. Separately, mem_done coinciding with the final watchdog cycle -> port_done=1, port_err=0.
- Async reset mid-transaction: assert reset while BUSY on port 2 -> granted, mem_rstrb and mem_wstrb are 0 immediately; after release port 0 wins first.
